uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver: next generation of the fixed 8N1 receiver on DE0.
//  - Configurable data width, stop-bit count and optional parity.
//  - Reports framing error and break condition per frame.
//  - Sits between the board RX pin and the image-loader byte path (50 MHz domain).

---
 rtl/uart_rx_cfg.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver: configurable data width, stop-bit count and optional parity.
// Build option UART_RX_PARITY_EN adds the parity bit and the o_Parity_Err flag.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
      STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_cfg: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    CLEANUP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ferr_q, ferr_d, stop_ferr;
  logic                   rx_meta_q, rx_meta_d, rx_data_q, rx_data_d, rx_prev_q, rx_prev_d;
  logic [1:0]             fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic                   dv_q, dv_d, busy_q, busy_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   frame_err_q, frame_err_d, break_q, break_d;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d, parity_err_q, parity_err_d;
`endif

  always_comb begin
    rx_meta_d   = i_Rx_Serial;
    rx_data_d   = rx_meta_q;
    rx_prev_d   = rx_data_q;
    fill_d      = {fill_q[0], 1'b1};
    // a line that is low straight out of reset must go high before a start is accepted
    armed_d     = armed_q | (fill_q[1] & rx_data_q);
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    ferr_d      = ferr_q;
    stop_ferr   = ferr_q | ~rx_data_q;
    dv_d        = 1'b0;
    byte_d      = byte_q;
    frame_err_d = frame_err_q;
    break_d     = break_q;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (armed_q && rx_prev_q && !rx_data_q) begin
          state_d = START;
          shift_d = '0;
          ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          state_d   = rx_data_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_data_q;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          perr_d    = ((^shift_q) ^ rx_data_q) != 1'(PARITY_ODD);
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          ferr_d    = stop_ferr;
          if (stop_idx_q == STOP_LAST) begin
            stop_idx_d  = 1'b0;
            byte_d      = shift_q;
            frame_err_d = stop_ferr;
            break_d     = stop_ferr && (shift_q == '0);
`ifdef UART_RX_PARITY_EN
            parity_err_d = perr_q;
`endif
            dv_d        = 1'b1;
            state_d     = CLEANUP;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_q   <= 1'b1;
      rx_data_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      dv_q        <= 1'b0;
      busy_q      <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_data_q   <= rx_data_d;
      rx_prev_q   <= rx_prev_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      dv_q        <= dv_d;
      busy_q      <= busy_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Break     = break_q;
  assign o_Busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = parity_err_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1 instance (A) driven from a vector table plus
// corner-case sequences, and a 7-bit / 2-stop instance (B).
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, rx_a = 1'b1, rx_b = 1'b1;
  logic dv_a, fe_a, pe_a, bk_a, by_a;
  logic [7:0] byte_a;
  logic dv_b, fe_b, pe_b, bk_b, by_b;
  logic [6:0] byte_b;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Frame_Err(fe_a), .o_Parity_Err(pe_a), .o_Break(bk_a), .o_Busy(by_a));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Frame_Err(fe_b), .o_Parity_Err(pe_b), .o_Break(bk_b), .o_Busy(by_b));

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;

  // capture every DV pulse (sampled on the falling edge)
  int dvn_a = 0, dvc_a = 0, dvn_b = 0, dvc_b = 0;
  logic [7:0] cb_a = '0;
  logic [6:0] cb_b = '0;
  logic cf_a = 0, cp_a = 0, ck_a = 0, cy_a = 0, cf_b = 0, cp_b = 0, ck_b = 0, cy_b = 0;
  always @(negedge clk) begin
    if (dv_a) begin
      dvn_a++; dvc_a = cyc; cb_a = byte_a; cf_a = fe_a; cp_a = pe_a; ck_a = bk_a; cy_a = by_a;
    end
    if (dv_b) begin
      dvn_b++; dvc_b = cyc; cb_b = byte_b; cf_b = fe_b; cp_b = pe_b; ck_b = bk_b; cy_b = by_b;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_lat(input string nm, input int lat, input int exp);
    total++;
    if (lat < exp - 1 || lat > exp + 1) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d+-1", nm, lat, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit which, input logic v, input int n);
    if (which) rx_b = v; else rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit which, input logic [8:0] data, input int nb, input logic par,
                      input logic [1:0] stop, input int ns, output int t0);
    t0 = cyc;
    drive(which, 1'b0, C);
    for (int i = 0; i < nb; i++) drive(which, data[i], C);
    if (P == 1) drive(which, par, C);
    for (int i = 0; i < ns; i++) drive(which, stop[i], C);
    if (which) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       ferr;
    logic       brk;
    logic       perr;
  } vec_t;
  vec_t vt[8];

  int t0, n0, lat_exp;

  initial begin
    vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    idle(3);
    chk("rst_dv", dv_a, 0);
    chk("rst_byte", byte_a, 0);
    chk("rst_flags", {fe_a, pe_a, bk_a}, 0);
    chk("rst_busy", by_a, 0);
    chk("rst_b", {dv_b, by_b, byte_b}, 0);
    rst = 1'b0;
    idle(8);

    lat_exp = (C - 1) / 2 + 1 + (8 + P + 1) * C;
    for (int i = 0; i < 8; i++) begin
      n0 = dvn_a;
      send(1'b0, {1'b0, vt[i].data}, 8, vt[i].par, {1'b1, vt[i].stop}, 1, t0);
      idle(2 * C);
      chk($sformatf("v%0d_dv_count", i), dvn_a - n0, 1);
      chk($sformatf("v%0d_byte", i), cb_a, vt[i].data);
      chk($sformatf("v%0d_frame_err", i), cf_a, vt[i].ferr);
      chk($sformatf("v%0d_break", i), ck_a, vt[i].brk);
      chk($sformatf("v%0d_parity_err", i), cp_a, (P == 1) ? vt[i].perr : 1'b0);
      chk($sformatf("v%0d_busy_at_dv", i), cy_a, 1);
      chk($sformatf("v%0d_busy_after", i), by_a, 0);
      chk_lat($sformatf("v%0d_latency", i), dvc_a - t0 - 2, lat_exp);
    end

    // reset during data bit 3, line left low across the reset release
    n0 = dvn_a;
    drive(1'b0, 1'b0, 4 * C + C / 2);
    rst = 1'b1;
    idle(1);
    chk("midrst_dv", dv_a, 0);
    chk("midrst_byte", byte_a, 0);
    chk("midrst_flags", {fe_a, pe_a, bk_a}, 0);
    chk("midrst_busy", by_a, 0);
    idle(2);
    rst = 1'b0;
    drive(1'b0, 1'b0, 2 * C);
    rx_a = 1'b1;
    idle(2 * C);
    chk("midrst_no_dv", dvn_a - n0, 0);
    send(1'b0, 9'h05A, 8, 1'b0, 2'b11, 1, t0);
    idle(2 * C);
    chk("after_rst_dv_count", dvn_a - n0, 1);
    chk("after_rst_byte", cb_a, 8'h5A);
    chk("after_rst_flags", {cf_a, cp_a, ck_a}, 0);

    // short low glitch: START rejects it
    n0 = dvn_a;
    drive(1'b0, 1'b0, 4);
    rx_a = 1'b1;
    chk("glitch_busy_rise", by_a, 1);
    idle(16);
    chk("glitch_busy_fall", by_a, 0);
    idle(2 * C);
    chk("glitch_no_dv", dvn_a - n0, 0);

    // line held low for 12 bit times: one break frame only
    n0 = dvn_a;
    drive(1'b0, 1'b0, 12 * C);
    rx_a = 1'b1;
    idle(4 * C);
    chk("brk_dv_count", dvn_a - n0, 1);
    chk("brk_byte", cb_a, 0);
    chk("brk_frame_err", cf_a, 1);
    chk("brk_break", ck_a, 1);
    chk("brk_parity_err", cp_a, 0);
    idle(12 * C);
    chk("brk_no_second", dvn_a - n0, 1);

    // 7 data bits, 2 stop bits
    lat_exp = (C - 1) / 2 + 1 + (7 + P + 2) * C;
    n0 = dvn_b;
    send(1'b1, 9'h055, 7, 1'b0, 2'b11, 2, t0);
    idle(2 * C);
    chk("b_dv_count", dvn_b - n0, 1);
    chk("b_byte", cb_b, 7'h55);
    chk("b_flags", {cf_b, cp_b, ck_b}, 0);
    chk_lat("b_latency", dvc_b - t0 - 2, lat_exp);
    chk("b_busy_after", by_b, 0);
    n0 = dvn_b;
    send(1'b1, 9'h02A, 7, 1'b1, 2'b01, 2, t0);
    idle(2 * C);
    chk("b2_dv_count", dvn_b - n0, 1);
    chk("b2_byte", cb_b, 7'h2A);
    chk("b2_frame_err", cf_b, 1);
    chk("b2_break", ck_b, 0);
    chk("b2_parity_err", cp_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
